// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Converts a binary value to BCD with a sequential double-dabble engine. It then
// time-multiplexes the resulting digits onto one shared BCD->7-segment decoder,
// driving one active-low enable per digit.
// Optional build macro: LEADING_ZERO_BLANK_EN. When defined, digits above the
// most-significant nonzero digit are blanked (bcd_out = 4'hF). Digit 0 is never blanked.
//
// Handshake: load is a request qualified by busy. A load sampled on a rising edge
// with busy=0 starts a conversion. Any load seen while busy=1 is dropped (no queue).
// done pulses for one cycle, and the display register takes the new digits at the
// end of that cycle.
module display_scan_ctrl #(
   parameter int WIDTH    = 16,
   parameter int NDIG     = 5,
   parameter int SCAN_DIV = 50000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] value,
   input  logic             load,
   output logic             busy,
   output logic             done,
   output logic [3:0]       bcd_out,
   output logic [NDIG-1:0]  digit_en_n,
   output logic [1:0]       conv_state
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [WIDTH-1:0]      shift_reg;
   logic [4*NDIG-1:0]     scratch;
   logic [4*NDIG-1:0]     scratch_adj;
   logic [CNT_W-1:0]      bitcnt;
   logic [4*NDIG-1:0]     display;
   logic [DIV_W-1:0]      div;
   logic [IDX_W-1:0]      index;
   logic [IDX_W-1:0]      index_next;
   logic                  wrap;
   logic [3:0]            shown_nib;

   // Converter state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Converter next-state: IDLE -> CONV for WIDTH cycles -> COMMIT -> IDLE
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (load) state_next = CONV;
         CONV:    if (bitcnt == CNT_W'(WIDTH - 1)) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Converter outputs, decoded only from the state register
   always_comb begin
      busy       = (state != IDLE);
      done       = (state == COMMIT);
      conv_state = state;
   end

   // Double-dabble correction: add 3 to every scratch nibble >= 5 before the shift
   always_comb begin
      scratch_adj = scratch;
      for (int i = 0; i < NDIG; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
   end

   // Conversion datapath and display register
   always_ff @(posedge clock) begin
      if (reset) begin
         shift_reg <= '0;
         scratch   <= '0;
         bitcnt    <= '0;
         display   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  shift_reg <= value;
                  scratch   <= '0;
                  bitcnt    <= '0;
               end
            end
            CONV: begin
               scratch   <= {scratch_adj[4*NDIG-2:0], shift_reg[WIDTH-1]};
               shift_reg <= shift_reg << 1;
               bitcnt    <= bitcnt + 1'b1;
            end
            COMMIT: begin
               display <= scratch;
            end
            default: begin
               display <= display;
            end
         endcase
      end
   end

   // Scan index that follows the current one, wrapping after the top digit
   always_comb begin
      wrap       = (div == DIV_W'(SCAN_DIV - 1));
      index_next = (index == IDX_W'(NDIG - 1)) ? '0 : index + 1'b1;
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Nibble for the next digit, blanked when it and every digit above it are zero
   always_comb begin
      logic upper_zero;
      shown_nib  = 4'hF;
      upper_zero = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (index_next == IDX_W'(i)) begin
            upper_zero = 1'b1;
            for (int j = i; j < NDIG; j++) begin
               if (display[4*j +: 4] != 4'd0) upper_zero = 1'b0;
            end
            shown_nib = (i != 0 && upper_zero) ? 4'hF : display[4*i +: 4];
         end
      end
   end
`else
   // Nibble for the next digit, leading zeros shown
   always_comb begin
      shown_nib = 4'hF;
      for (int i = 0; i < NDIG; i++) begin
         if (index_next == IDX_W'(i)) shown_nib = display[4*i +: 4];
      end
   end
`endif

   // Free-running scan divider; on each wrap move to the next digit and refresh pins
   always_ff @(posedge clock) begin
      if (reset) begin
         div        <= '0;
         index      <= '0;
         digit_en_n <= '1;
         bcd_out    <= 4'hF;
      end else if (wrap) begin
         div        <= '0;
         index      <= index_next;
         digit_en_n <= ~(NDIG'(1) << index_next);
         bcd_out    <= shown_nib;
      end else begin
         div <= div + 1'b1;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (WIDTH=16, NDIG=5, SCAN_DIV=4).
// Expected digits follow the LEADING_ZERO_BLANK_EN setting of the build.
module tb_display_scan_ctrl;

   localparam int WIDTH    = 16;
   localparam int NDIG     = 5;
   localparam int SCAN_DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [19:0] EXP_ZERO = 20'hFFFF0;
   localparam logic [19:0] EXP_100  = 20'hFF100;
   localparam logic [19:0] EXP_42   = 20'hFFF42;
`else
   localparam logic [19:0] EXP_ZERO = 20'h00000;
   localparam logic [19:0] EXP_100  = 20'h00100;
   localparam logic [19:0] EXP_42   = 20'h00042;
`endif

   logic             clock;
   logic             reset;
   logic [WIDTH-1:0] value;
   logic             load;
   logic             busy;
   logic             done;
   logic [3:0]       bcd_out;
   logic [NDIG-1:0]  digit_en_n;
   logic [1:0]       conv_state;

   int checks;
   int errors;

   display_scan_ctrl #(
      .WIDTH   (WIDTH),
      .NDIG    (NDIG),
      .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .value     (value),
      .load      (load),
      .busy      (busy),
      .done      (done),
      .bcd_out   (bcd_out),
      .digit_en_n(digit_en_n),
      .conv_state(conv_state)
   );

   // Clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Present value with load for exactly one rising edge; returns at the
   // negedge of the first cycle after the load edge.
   task automatic load_value(input logic [WIDTH-1:0] v);
      @(negedge clock);
      value = v;
      load  = 1'b1;
      @(negedge clock);
      load  = 1'b0;
   endtask

   // Count busy/done cycles; cycle numbering starts at 'start' (1 = first cycle after load edge)
   task automatic measure(input int start, output int busy_cnt, output int done_cnt,
                          output int done_at);
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = 0;
      for (int c = start; c < start + 40; c++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_at = c;
         end
         if (!busy) break;
         @(negedge clock);
      end
   endtask

   // Wait for a fresh scan update, then read digits 0..NDIG-1 in turn
   task automatic check_digits(input logic [19:0] exp, input string tag);
      logic [NDIG-1:0] prev;
      logic [NDIG-1:0] want;
      int t;
      prev = digit_en_n;
      t = 0;
      while (digit_en_n === prev && t < 30) begin
         @(negedge clock);
         t++;
      end
      check({tag, "_sync"}, 32'(t < 30), 32'd1);
      for (int i = 0; i < NDIG; i++) begin
         want = ~(NDIG'(1) << i);
         t = 0;
         while (digit_en_n !== want && t < 30) begin
            @(negedge clock);
            t++;
         end
         check($sformatf("%s_en%0d", tag, i), 32'(digit_en_n), 32'(want));
         check($sformatf("%s_d%0d", tag, i), 32'(bcd_out), 32'(exp[4*i +: 4]));
      end
   endtask

   // Follow the enable rotation for several steps and check hold time and order
   task automatic check_scan(input int steps);
      logic [NDIG-1:0] prev;
      logic [NDIG-1:0] cur;
      logic [NDIG-1:0] rot;
      int t;
      int hold;
      prev = digit_en_n;
      t = 0;
      while (digit_en_n === prev && t < 30) begin
         @(negedge clock);
         t++;
      end
      check("scan_sync", 32'(t < 30), 32'd1);
      for (int s = 0; s < steps; s++) begin
         cur  = digit_en_n;
         rot  = {cur[NDIG-2:0], cur[NDIG-1]};
         hold = 0;
         while (digit_en_n === cur && hold < 20) begin
            hold++;
            @(negedge clock);
         end
         check($sformatf("scan_onehot%0d", s), 32'($countones(~cur)), 32'd1);
         check($sformatf("scan_hold%0d", s), 32'(hold), SCAN_DIV);
         check($sformatf("scan_next%0d", s), 32'(digit_en_n), 32'(rot));
      end
   endtask

   // Directed sequence
   initial begin
      int busy_cnt;
      int done_cnt;
      int done_at;
      int seen_done;

      checks = 0;
      errors = 0;
      reset  = 1'b1;
      load   = 1'b0;
      value  = '0;

      // 1) reset for 3 cycles, then release
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_bcd",   32'(bcd_out), 32'hF);
      check("rst_en",    32'(digit_en_n), 32'h1F);
      check("rst_state", 32'(conv_state), 32'd0);
      @(negedge clock);
      check("rst_en_hold", 32'(digit_en_n), 32'h1F);

      // 2) 12345: 17 busy cycles, done in cycle 17
      load_value(16'd12345);
      measure(1, busy_cnt, done_cnt, done_at);
      check("c12345_busy",   32'(busy_cnt), 32'd17);
      check("c12345_ndone",  32'(done_cnt), 32'd1);
      check("c12345_doneat", 32'(done_at), 32'd17);
      check_digits(20'h12345, "c12345");

      // 3) 65535, then 0
      load_value(16'd65535);
      measure(1, busy_cnt, done_cnt, done_at);
      check("c65535_busy", 32'(busy_cnt), 32'd17);
      check_digits(20'h65535, "c65535");
      load_value(16'd0);
      measure(1, busy_cnt, done_cnt, done_at);
      check("c0_ndone", 32'(done_cnt), 32'd1);
      check_digits(EXP_ZERO, "c0");

      // 4) 100, then 999 three cycles later while busy: ignored
      load_value(16'd100);
      @(negedge clock);
      @(negedge clock);
      check("c100_busy_at3", 32'(busy), 32'd1);
      value = 16'd999;
      load  = 1'b1;
      @(negedge clock);
      load  = 1'b0;
      measure(4, busy_cnt, done_cnt, done_at);
      check("c100_busy",   32'(busy_cnt + 3), 32'd17);
      check("c100_ndone",  32'(done_cnt), 32'd1);
      check("c100_doneat", 32'(done_at), 32'd17);
      check_digits(EXP_100, "c100");

      // 5) enable rotation holds across a conversion of 42
      load_value(16'd42);
      check_scan(6);
      check("c42_idle", 32'(busy), 32'd0);

      // 6) 42 digits
      check_digits(EXP_42, "c42");

      // 7) reset in cycle 8 of a conversion
      load_value(16'd777);
      repeat (7) @(negedge clock);
      check("abort_busy_pre", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      check("abort_busy",  32'(busy), 32'd0);
      check("abort_done",  32'(done), 32'd0);
      check("abort_bcd",   32'(bcd_out), 32'hF);
      check("abort_en",    32'(digit_en_n), 32'h1F);
      check("abort_state", 32'(conv_state), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      seen_done = 0;
      for (int c = 0; c < 30; c++) begin
         if (done) seen_done++;
         @(negedge clock);
      end
      check("abort_nodone", 32'(seen_done), 32'd0);
      check_digits(EXP_ZERO, "abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
